// File: rtl/aes_link_pkg.sv
// Shared types and constants for the AES host-side pin link.
//   tx_state_t : transmit sequencer states
//   byte_idx_t : index of a byte within a 32-bit word (0 = MSB byte)
//   sel_byte   : MSB-first byte extraction
package aes_link_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned GAP_W   = 4;   // holds GAP values 0..15
  localparam int unsigned TIMER_W = 16;  // holds RX_TIMEOUT values up to 65535

  localparam int unsigned DEF_GAP        = 1;
  localparam int unsigned DEF_RX_TIMEOUT = 255;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  typedef logic [1:0] byte_idx_t;

  // Byte idx of a word, idx 0 being bits [31:24].
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [WORD_W-1:0] w,
                                                 input byte_idx_t         idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_link_rx_deser.sv
// Receive deserializer: packs bytes strobed by sho into 32-bit words,
// first byte in [31:24]; drops a partial word after RX_TIMEOUT idle cycles.
//   clk, rst          : clock, synchronous active-high reset
//   chip_data, sho    : byte from the chip and its strobe
//   rx_word           : last completed word
//   rx_valid, rx_err  : one-cycle pulses for word completion / partial drop
module aes_link_rx_deser
  import aes_link_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = DEF_RX_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] chip_data,
  input  logic              sho,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_valid,
  output logic              rx_err
);

  logic [23:0]        acc;    // up to three earlier bytes of the current word
  byte_idx_t          count;  // bytes held in acc
  logic [TIMER_W-1:0] timer;  // cycles since the last sho, 1 in the cycle after it

  // Shift, complete, and time out partial words.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      timer    <= '0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (sho) begin
        // A byte in the expiry cycle wins over the timeout.
        acc   <= {acc[15:0], chip_data};
        count <= count + 2'd1;
        if (count == 2'd3) begin
          rx_word  <= {acc, chip_data};
          rx_valid <= 1'b1;
          timer    <= '0;
        end else begin
          timer <= TIMER_W'(1);
        end
      end else if (count != 2'd0) begin
        if (timer == TIMER_W'(RX_TIMEOUT)) begin
          acc    <= '0;
          count  <= '0;
          timer  <= '0;
          rx_err <= 1'b1;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/aes_host_link.sv
// Host-side link to the AES chip's byte-wide pin protocol.
// TX: serializes 32-bit words MSB byte first, one shi strobe per byte with
// GAP idle cycles after each byte. RX: deserializes chip_data/sho into words.
//   clk, rst                      : clock, synchronous active-high reset
//   tx_word, tx_valid, tx_ready   : word-level transmit handshake
//   tx_busy                       : transmit sequence in progress
//   user_data, shi                : byte and strobe to the chip
//   chip_data, sho                : byte and strobe from the chip
//   rx_word, rx_valid, rx_err     : received word, completion / drop pulses
module aes_host_link
  import aes_link_pkg::*;
#(
  parameter int unsigned GAP        = DEF_GAP,
  parameter int unsigned RX_TIMEOUT = DEF_RX_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tx_word,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic [BYTE_W-1:0] user_data,
  output logic              shi,
  input  logic [BYTE_W-1:0] chip_data,
  input  logic              sho,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_valid,
  output logic              rx_err
);

  tx_state_t          state;
  byte_idx_t          idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [WORD_W-1:0]  word;

  // Transmit sequencer; every output is set for the cycle it applies to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      word      <= '0;
      user_data <= '0;
      shi       <= 1'b0;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      shi <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            word      <= tx_word;
            idx       <= '0;
            user_data <= sel_byte(tx_word, 2'd0);
            shi       <= 1'b1;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (GAP > 0) begin
            gap_cnt <= GAP_W'(GAP);
            state   <= TX_GAP;
          end else if (idx == 2'd3) begin
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= TX_IDLE;
          end else begin
            idx       <= idx + 2'd1;
            user_data <= sel_byte(word, idx + 2'd1);
            shi       <= 1'b1;
          end
        end
        TX_GAP: begin
          // user_data keeps the last byte through the gap.
          if (gap_cnt == GAP_W'(1)) begin
            if (idx == 2'd3) begin
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              state    <= TX_IDLE;
            end else begin
              idx       <= idx + 2'd1;
              user_data <= sel_byte(word, idx + 2'd1);
              shi       <= 1'b1;
              state     <= TX_SEND;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  aes_link_rx_deser #(
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_rx_deser (
    .clk       (clk),
    .rst       (rst),
    .chip_data (chip_data),
    .sho       (sho),
    .rx_word   (rx_word),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err)
  );

endmodule
